// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes, ALU codes, FSM states.
// The optional bne support is selected with the MC_BNE_EN macro in mc_controller.
package mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_BRANCHNE = 4'd12
    } state_t;

    // Per-state control bundle before reset gating
    typedef struct packed {
        logic                iord;
        logic                mem_write;
        logic                ir_write;
        logic                reg_write;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                alu_src_a;
        logic [SEL_W-1:0]    alu_src_b;
        logic [SEL_W-1:0]    pc_src;
        logic                pc_write;
        logic                branch;
        logic                branch_taken;
        logic [ALUOP_W-1:0]  aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps the FSM aluop and the R-type funct field to an ALU control code.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [ALUOP_W-1:0]  aluop,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM for a shared instruction/data memory, stalled by the memory ready handshake.
// Define MC_BNE_EN to add the BRANCHNE state for bne; otherwise bne is dropped as an unsupported opcode.
module mc_controller
    import mc_pkg::*;
(
    input  logic                i_clk_w,
    input  logic                i_rst_w,
    input  logic [OP_W-1:0]     i_op_w,
    input  logic [FUNCT_W-1:0]  i_funct_w,
    input  logic                i_zero_w,
    input  logic                i_mem_ready_w,
    output logic                o_iord_w,
    output logic                o_mem_write_w,
    output logic                o_ir_write_w,
    output logic                o_reg_write_w,
    output logic                o_reg_dst_w,
    output logic                o_mem_to_reg_w,
    output logic                o_alu_src_a_w,
    output logic [SEL_W-1:0]    o_alu_src_b_w,
    output logic [SEL_W-1:0]    o_pc_src_w,
    output logic                o_pc_en_w,
    output logic [ALUCTL_W-1:0] o_alu_control_w,
    output logic [STATE_W-1:0]  o_state_w
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;

    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;
        ctrl.aluop = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = i_mem_ready_w;
                ctrl.pc_write  = i_mem_ready_w;
                if (i_mem_ready_w) next_state = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                case (i_op_w)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       next_state = S_BRANCHNE;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                next_state     = (i_op_w == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                if (i_mem_ready_w) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (i_mem_ready_w) next_state = S_FETCH;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.aluop     = ALUOP_FUNCT;
                next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                next_state     = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_B;
                ctrl.aluop        = ALUOP_SUB;
                ctrl.pc_src       = PCSRC_ALUOUT;
                ctrl.branch       = 1'b1;
                ctrl.branch_taken = i_zero_w;
                next_state        = S_FETCH;
            end
`ifdef MC_BNE_EN
            S_BRANCHNE: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_B;
                ctrl.aluop        = ALUOP_SUB;
                ctrl.pc_src       = PCSRC_ALUOUT;
                ctrl.branch       = 1'b1;
                ctrl.branch_taken = ~i_zero_w;
                next_state        = S_FETCH;
            end
`endif
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                next_state     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                next_state     = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                next_state    = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .aluop       (ctrl.aluop),
        .funct       (i_funct_w),
        .alu_control (o_alu_control_w)
    );

    // Architectural writes are suppressed for the whole time reset is asserted
    assign o_mem_write_w  = ctrl.mem_write & ~i_rst_w;
    assign o_ir_write_w   = ctrl.ir_write  & ~i_rst_w;
    assign o_reg_write_w  = ctrl.reg_write & ~i_rst_w;
    assign o_pc_en_w      = (ctrl.pc_write | (ctrl.branch & ctrl.branch_taken)) & ~i_rst_w;

    assign o_iord_w       = ctrl.iord;
    assign o_reg_dst_w    = ctrl.reg_dst;
    assign o_mem_to_reg_w = ctrl.mem_to_reg;
    assign o_alu_src_a_w  = ctrl.alu_src_a;
    assign o_alu_src_b_w  = ctrl.alu_src_b;
    assign o_pc_src_w     = ctrl.pc_src;
    assign o_state_w      = state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction step sequences from the ISA rules feed an expectation queue
// checked every cycle, with literal spot checks; honours MC_BNE_EN the same way the design does.
module tb_mc_controller;

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MWR = 5, EX = 6, AWB = 7,
                   BR = 8, AE = 9, AIW = 10, JMP = 11, BN = 12;

    localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           ADDI = 6'b001000, JOP = 6'b000010, BNE = 6'b000101, BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pe;
        logic [2:0] alu;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   path_q[$];
    logic [5:0] cur_op, cur_fn;
    logic       cur_z;

    mc_controller dut (
        .i_clk_w         (clk),
        .i_rst_w         (rst),
        .i_op_w          (op),
        .i_funct_w       (funct),
        .i_zero_w        (zero),
        .i_mem_ready_w   (mem_ready),
        .o_iord_w        (iord),
        .o_mem_write_w   (mem_write),
        .o_ir_write_w    (ir_write),
        .o_reg_write_w   (reg_write),
        .o_reg_dst_w     (reg_dst),
        .o_mem_to_reg_w  (mem_to_reg),
        .o_alu_src_a_w   (alu_src_a),
        .o_alu_src_b_w   (alu_src_b),
        .o_pc_src_w      (pc_src),
        .o_pc_en_w       (pc_en),
        .o_alu_control_w (alu_control),
        .o_state_w       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // What the outputs must be in a given step of an instruction
    function automatic exp_t model(input int st, input logic rdy, input logic z,
                                   input logic [5:0] fn, input logic r);
        exp_t e;
        e     = '0;
        e.st  = 4'(st);
        e.alu = 3'b010;
        case (st)
            F:   begin e.sb = 2'b01; e.irw = rdy; e.pe = rdy; end
            D:   e.sb = 2'b11;
            MA:  begin e.sa = 1'b1; e.sb = 2'b10; end
            MR:  e.iord = 1'b1;
            MWB: begin e.m2r = 1'b1; e.rw = 1'b1; end
            MWR: begin e.iord = 1'b1; e.mw = 1'b1; end
            EX:  begin e.sa = 1'b1; e.alu = funct_alu(fn); end
            AWB: begin e.rd = 1'b1; e.rw = 1'b1; end
            BR:  begin e.sa = 1'b1; e.ps = 2'b01; e.alu = 3'b110; e.pe = z; end
            BN:  begin e.sa = 1'b1; e.ps = 2'b01; e.alu = 3'b110; e.pe = ~z; end
            AE:  begin e.sa = 1'b1; e.sb = 2'b10; end
            AIW: e.rw = 1'b1;
            JMP: begin e.ps = 2'b10; e.pe = 1'b1; end
            default: ;
        endcase
        if (r) begin
            e.mw  = 1'b0;
            e.irw = 1'b0;
            e.rw  = 1'b0;
            e.pe  = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // One clock cycle in step st: drive inputs and queue the expectation
    task automatic step(input int st, input logic rdy, input logic r);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        op        = cur_op;
        funct     = cur_fn;
        zero      = cur_z;
        exp_q.push_back(model(st, rdy, cur_z, cur_fn, r));
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input logic z,
                             input int fstall, input int mstall);
        int ns;
        cur_op = o;
        cur_fn = fn;
        cur_z  = z;
        path_q.delete();
        path_q.push_back(F);
        path_q.push_back(D);
        case (o)
            LW:   begin path_q.push_back(MA); path_q.push_back(MR); path_q.push_back(MWB); end
            SW:   begin path_q.push_back(MA); path_q.push_back(MWR); end
            R_OP: begin path_q.push_back(EX); path_q.push_back(AWB); end
            BEQ:  path_q.push_back(BR);
            ADDI: begin path_q.push_back(AE); path_q.push_back(AIW); end
            JOP:  path_q.push_back(JMP);
`ifdef MC_BNE_EN
            BNE:  path_q.push_back(BN);
`endif
            default: ;
        endcase
        foreach (path_q[k]) begin
            if (path_q[k] == F || path_q[k] == MR || path_q[k] == MWR) begin
                ns = (path_q[k] == F) ? fstall : mstall;
                for (int i = 0; i <= ns; i++) step(path_q[k], (i == ns), 1'b0);
            end else begin
                step(path_q[k], 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() != 0) begin
            e     = exp_q.pop_front();
            a.st  = state;
            a.iord = iord;
            a.mw  = mem_write;
            a.irw = ir_write;
            a.rw  = reg_write;
            a.rd  = reg_dst;
            a.m2r = mem_to_reg;
            a.sa  = alu_src_a;
            a.sb  = alu_src_b;
            a.ps  = pc_src;
            a.pe  = pc_en;
            a.alu = alu_control;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle t=%0t state got=%0d want=%0d ctrl got=%h want=%h",
                         $time, a.st, e.st, a, e);
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
        cur_op = '0; cur_fn = '0; cur_z = 1'b0;

        // Power-on reset, two cycles
        step(F, 1'b1, 1'b1);
        #1; chk("rst_state", 32'(state), 0);
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_ir_write", 32'(ir_write), 0);
        step(F, 1'b1, 1'b1);

        // lw with memory always ready
        cur_op = LW;
        step(F, 1'b1, 1'b0);
        #1; chk("lw_fetch_irw", 32'(ir_write), 1);
        chk("lw_fetch_pc_en", 32'(pc_en), 1);
        chk("lw_fetch_srcb", 32'(alu_src_b), 1);
        step(D, 1'b1, 1'b0);
        #1; chk("lw_decode_srcb", 32'(alu_src_b), 3);
        chk("lw_decode_pc_en", 32'(pc_en), 0);
        step(MA, 1'b1, 1'b0);
        step(MR, 1'b1, 1'b0);
        #1; chk("lw_memrd_iord", 32'(iord), 1);
        step(MWB, 1'b1, 1'b0);
        #1; chk("lw_memwb_regwrite", 32'(reg_write), 1);
        chk("lw_memwb_state", 32'(state), 4);

        // sw with three not-ready cycles in MEMWR
        run_instr(SW, 6'd0, 1'b0, 0, 3);

        // R-type slt
        cur_op = R_OP; cur_fn = 6'b101010; cur_z = 1'b0;
        step(F, 1'b1, 1'b0);
        step(D, 1'b0, 1'b0);
        step(EX, 1'b1, 1'b0);
        #1; chk("slt_alu", 32'(alu_control), 32'h7);
        step(AWB, 1'b0, 1'b0);
        #1; chk("aluwb_reg_dst", 32'(reg_dst), 1);
        chk("aluwb_reg_write", 32'(reg_write), 1);

        // beq taken
        cur_op = BEQ; cur_fn = 6'd0; cur_z = 1'b1;
        step(F, 1'b1, 1'b0);
        step(D, 1'b1, 1'b0);
        step(BR, 1'b0, 1'b0);
        #1; chk("beq_taken_pc_en", 32'(pc_en), 1);
        chk("beq_pc_src", 32'(pc_src), 1);
        chk("beq_alu_sub", 32'(alu_control), 32'h6);

        // jump
        cur_op = JOP; cur_z = 1'b0;
        step(F, 1'b1, 1'b0);
        step(D, 1'b1, 1'b0);
        step(JMP, 1'b0, 1'b0);
        #1; chk("j_pc_en", 32'(pc_en), 1);
        chk("j_pc_src", 32'(pc_src), 2);

        run_instr(BEQ,  6'd0,      1'b0, 0, 0);
        run_instr(BNE,  6'd0,      1'b0, 0, 0);
        run_instr(BNE,  6'd0,      1'b1, 1, 0);
        run_instr(R_OP, 6'b100000, 1'b0, 0, 0);
        run_instr(R_OP, 6'b100010, 1'b1, 0, 0);
        run_instr(R_OP, 6'b100100, 1'b0, 2, 0);
        run_instr(R_OP, 6'b100101, 1'b0, 0, 0);
        run_instr(R_OP, 6'b111111, 1'b0, 0, 0);
        run_instr(ADDI, 6'd0,      1'b0, 1, 0);
        run_instr(BAD,  6'd0,      1'b0, 0, 0);
        run_instr(LW,   6'd0,      1'b0, 2, 2);
        run_instr(SW,   6'd0,      1'b0, 1, 0);
        run_instr(BEQ,  6'd0,      1'b1, 3, 0);

        // Reset while a store is stalled in MEMWR
        cur_op = SW; cur_fn = 6'd0; cur_z = 1'b0;
        step(F, 1'b1, 1'b0);
        step(D, 1'b1, 1'b0);
        step(MA, 1'b1, 1'b0);
        step(MWR, 1'b0, 1'b0);
        step(MWR, 1'b1, 1'b1);
        #1; chk("rst_memwr_mem_write", 32'(mem_write), 0);
        step(F, 1'b1, 1'b1);
        #1; chk("rst_fetch_ir_write", 32'(ir_write), 0);
        chk("rst_fetch_state", 32'(state), 0);
        run_instr(R_OP, 6'b100000, 1'b0, 0, 0);
        run_instr(LW,   6'd0,      1'b0, 0, 1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
